expr_vec_sequencer: RTL and testbench

- Sequences a wide combinational expression block: drives the 60-bit packed operand bus {a0..a5,b0..b5} from an LFSR.
- Waits a programmable settle time, then folds the 90-bit y result into a 32-bit MISR signature.
- Runs NUM_VEC vectors per start command and reports the signature, the vector count and done.
- Sits between the regression harness and one expression instance; a second, reference instance is optional.

---
 rtl/expr_vec_sequencer.sv | 154 +++++++++++++++
 tb/tb_expr_vec_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_vec_sequencer.sv
// Drives LFSR operand vectors into an expression block and folds its results into a MISR signature.
// Define EXPR_VEC_SEQ_CMP_EN to add a reference-result comparator (ref_y, mismatch_cnt, first_bad_idx).
module expr_vec_sequencer #(
  parameter int          NUM_VEC    = 256,
  parameter int          SETTLE_CYC = 1,
  parameter int          OP_W       = 60,
  parameter int          Y_W        = 90,
  parameter logic [31:0] MISR_POLY  = 32'h04C11DB7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [63:0]     seed,
  output logic [OP_W-1:0] op_vec,
  output logic            op_valid,
  input  logic [Y_W-1:0]  dut_y,
`ifdef EXPR_VEC_SEQ_CMP_EN
  input  logic [Y_W-1:0]  ref_y,
  output logic [15:0]     mismatch_cnt,
  output logic [15:0]     first_bad_idx,
`endif
  output logic            busy,
  output logic            done,
  output logic [15:0]     vec_idx,
  output logic [31:0]     signature
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRIVE,
    SETTLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [15:0] LAST_IDX    = 16'(NUM_VEC - 1);
  localparam logic [3:0]  SETTLE_LOAD = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] lfsr;
  logic [63:0] lfsr_nxt;
  logic [3:0]  settle_cnt;
  logic        last_vec;
  logic [95:0] y_pad;
  logic [31:0] fold;
  logic [31:0] sig_nxt;

  assign last_vec = (vec_idx == LAST_IDX);

  // Fibonacci LFSR, taps 64/63/61/60, new bit enters at bit 0.
  assign lfsr_nxt = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};

  // The result is zero-extended to three 32-bit words and folded together before entering the MISR.
  assign y_pad   = 96'(dut_y);
  assign fold    = y_pad[31:0] ^ y_pad[63:32] ^ y_pad[95:64];
  assign sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = LOAD;
        LOAD:    state_nxt = DRIVE;
        DRIVE:   state_nxt = (SETTLE_CYC > 0) ? SETTLE : CAPTURE;
        SETTLE:  if (settle_cnt == 4'd0) state_nxt = CAPTURE;
        CAPTURE: state_nxt = last_vec ? DONE : DRIVE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LOAD, DRIVE, SETTLE, CAPTURE: busy = 1'b1;
      DONE:                         done = 1'b1;
      default: ;
    endcase
  end

  // Abort freezes the datapath so signature and vec_idx keep whatever the run had reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= 64'h1;
      op_vec     <= '0;
      op_valid   <= 1'b0;
      vec_idx    <= 16'd0;
      signature  <= 32'd0;
      settle_cnt <= 4'd0;
    end else if (abort) begin
      op_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          lfsr      <= (seed == 64'd0) ? 64'h1 : seed;
          signature <= 32'd0;
          vec_idx   <= 16'd0;
        end
        DRIVE: begin
          op_vec     <= lfsr[OP_W-1:0];
          op_valid   <= 1'b1;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end
        CAPTURE: begin
          signature <= sig_nxt;
          lfsr      <= lfsr_nxt;
          if (last_vec) begin
            op_valid <= 1'b0;
          end else begin
            vec_idx <= vec_idx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EXPR_VEC_SEQ_CMP_EN
  // The first mismatch is recognised by the counter still being zero when it happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt  <= 16'd0;
      first_bad_idx <= 16'hFFFF;
    end else if (!abort) begin
      if (state == LOAD) begin
        mismatch_cnt  <= 16'd0;
        first_bad_idx <= 16'hFFFF;
      end else if (state == CAPTURE && ref_y != dut_y) begin
        if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
        if (mismatch_cnt == 16'd0) first_bad_idx <= vec_idx;
      end
    end
  end
`endif

endmodule

// File: tb/tb_expr_vec_sequencer.sv
// Self-checking bench for expr_vec_sequencer: three instances with different NUM_VEC/SETTLE_CYC,
// table-driven and random runs against a behavioural model, plus abort/reset/compare corner cases.
module tb_expr_vec_sequencer;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic [63:0] seed;
  logic        start_a, start_b, start_c;
  logic        y_const_mode;
  logic [89:0] y_const;
  logic        cmp_mode;

  logic [59:0] a_op, b_op, c_op;
  logic        a_ov, b_ov, c_ov, a_busy, b_busy, c_busy, a_done, b_done, c_done;
  logic [15:0] a_idx, b_idx, c_idx;
  logic [31:0] a_sig, b_sig, c_sig;
  logic [89:0] a_y, b_y, c_y;
`ifdef EXPR_VEC_SEQ_CMP_EN
  logic [89:0] b_ref;
  logic [15:0] a_mm, a_fb, b_mm, b_fb, c_mm, c_fb;
`endif

  int nvec = 0;
  int nmis = 0;
  logic [59:0] exp_op [16];
  logic [59:0] op_seen [16];
  bit          seen [16];

  always #5 clk = ~clk;

  // Stand-in for the expression block: an arbitrary but fixed function of the operand bus.
  function automatic logic [89:0] expr_fn(input logic [59:0] op);
    return {op[29:0] ^ 30'h2AAA_AAAA, op ^ {op[30:0], op[59:31]}};
  endfunction

  function automatic logic [63:0] lfsr_fn(input logic [63:0] s);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return (s << 1) | {63'd0, fb};
  endfunction

  function automatic logic [31:0] misr_fn(input logic [31:0] sig, input logic [89:0] y);
    logic [31:0] w0, w1, w2;
    w0 = y[31:0];
    w1 = y[63:32];
    w2 = 32'(y[89:64]);
    return (sig << 1) ^ (sig[31] ? POLY : 32'd0) ^ w0 ^ w1 ^ w2;
  endfunction

  assign a_y = y_const_mode ? y_const : expr_fn(a_op);
  assign b_y = y_const_mode ? y_const : expr_fn(b_op);
  assign c_y = y_const_mode ? y_const : expr_fn(c_op);
`ifdef EXPR_VEC_SEQ_CMP_EN
  assign b_ref = (cmp_mode && (b_idx == 16'd5 || b_idx == 16'd9)) ? (b_y ^ 90'h1) : b_y;
`endif

  expr_vec_sequencer #(.NUM_VEC(4), .SETTLE_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .seed(seed),
    .op_vec(a_op), .op_valid(a_ov), .dut_y(a_y),
`ifdef EXPR_VEC_SEQ_CMP_EN
    .ref_y(a_y), .mismatch_cnt(a_mm), .first_bad_idx(a_fb),
`endif
    .busy(a_busy), .done(a_done), .vec_idx(a_idx), .signature(a_sig));

  expr_vec_sequencer #(.NUM_VEC(16), .SETTLE_CYC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .seed(seed),
    .op_vec(b_op), .op_valid(b_ov), .dut_y(b_y),
`ifdef EXPR_VEC_SEQ_CMP_EN
    .ref_y(b_ref), .mismatch_cnt(b_mm), .first_bad_idx(b_fb),
`endif
    .busy(b_busy), .done(b_done), .vec_idx(b_idx), .signature(b_sig));

  expr_vec_sequencer #(.NUM_VEC(2), .SETTLE_CYC(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .seed(seed),
    .op_vec(c_op), .op_valid(c_ov), .dut_y(c_y),
`ifdef EXPR_VEC_SEQ_CMP_EN
    .ref_y(c_y), .mismatch_cnt(c_mm), .first_bad_idx(c_fb),
`endif
    .busy(c_busy), .done(c_done), .vec_idx(c_idx), .signature(c_sig));

  logic [1:0]  sel;
  logic [59:0] cur_op;
  logic        cur_ov, cur_busy, cur_done;
  logic [15:0] cur_idx;
  logic [31:0] cur_sig;

  always_comb begin
    cur_op = a_op; cur_ov = a_ov; cur_busy = a_busy; cur_done = a_done; cur_idx = a_idx; cur_sig = a_sig;
    case (sel)
      2'd1: begin
        cur_op = b_op; cur_ov = b_ov; cur_busy = b_busy; cur_done = b_done; cur_idx = b_idx; cur_sig = b_sig;
      end
      2'd2: begin
        cur_op = c_op; cur_ov = c_ov; cur_busy = c_busy; cur_done = c_done; cur_idx = c_idx; cur_sig = c_sig;
      end
      default: ;
    endcase
  end

  function automatic int nv_of(input logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd1) ? 16 : 2;
  endfunction

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 + 4 * 3 : (s == 2'd1) ? 1 + 16 * 4 : 1 + 2 * 2;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [1:0] s, input logic v);
    case (s)
      2'd0: start_a = v;
      2'd1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic model_run(input logic [63:0] sd, input int n, input logic ym, input logic [89:0] yc,
                           output logic [31:0] sig);
    logic [63:0] s;
    logic [89:0] y;
    s   = (sd == 64'd0) ? 64'd1 : sd;
    sig = 32'd0;
    for (int i = 0; i < n; i++) begin
      exp_op[i] = s[59:0];
      y   = ym ? yc : expr_fn(s[59:0]);
      sig = misr_fn(sig, y);
      s   = lfsr_fn(s);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] seed;
    logic        ymode;
    logic [89:0] yconst;
    bit          mid_start;
    bit          has_exp;
    logic [31:0] exp_sig;
    logic [59:0] exp_op0;
    int          lat;
  } vec_t;

  logic [31:0] last_sig;

  task automatic applyStimulus(input vec_t v);
    int n;
    int cycles;
    logic [31:0] msig;
    sel = v.sel; seed = v.seed; y_const_mode = v.ymode; y_const = v.yconst;
    n = nv_of(v.sel);
    model_run(v.seed, n, v.ymode, v.yconst, msig);
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    @(negedge clk);
    drive_start(v.sel, 1'b1);
    @(posedge clk); #1;
    drive_start(v.sel, 1'b0);
    checkOutput("busy_after_accept", 64'(cur_busy), 64'd1);
    cycles = 0;
    while (!cur_done && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      drive_start(v.sel, v.mid_start && cycles == 5);
      if (cur_ov && cur_idx < 16) begin
        op_seen[cur_idx] = cur_op;
        seen[cur_idx]    = 1'b1;
      end
    end
    drive_start(v.sel, 1'b0);
    checkOutput("latency", 64'(cycles), 64'(v.lat));
    checkOutput("signature", 64'(cur_sig), 64'(msig));
    checkOutput("vec_idx_final", 64'(cur_idx), 64'(n - 1));
    checkOutput("op_valid_in_done", 64'(cur_ov), 64'd0);
    checkOutput("busy_in_done", 64'(cur_busy), 64'd0);
    for (int i = 0; i < n; i++) begin
      checkOutput("op_vec_seen", 64'(seen[i]), 64'd1);
      checkOutput("op_vec", 64'(op_seen[i]), 64'(exp_op[i]));
    end
    if (v.has_exp) begin
      checkOutput("signature_const", 64'(cur_sig), 64'(v.exp_sig));
      checkOutput("first_op_vec", 64'(op_seen[0]), 64'(v.exp_op0));
    end
`ifdef EXPR_VEC_SEQ_CMP_EN
    if (v.sel == 2'd1) begin
      checkOutput("mismatch_cnt", 64'(b_mm), cmp_mode ? 64'd2 : 64'd0);
      checkOutput("first_bad_idx", 64'(b_fb), cmp_mode ? 64'd5 : 64'hFFFF);
    end
`endif
    @(posedge clk); #1;
    checkOutput("done_one_cycle", 64'(cur_done), 64'd0);
    checkOutput("signature_held", 64'(cur_sig), 64'(msig));
    last_sig = msig;
  endtask

  vec_t tbl [6];

  initial begin
    vec_t v;
    int dones;
    logic [31:0] msig2;

    tbl[0] = '{2'd0, 64'h1, 1'b1, 90'h0, 1'b0, 1'b1, 32'h0, 60'h1, 13};
    tbl[1] = '{2'd0, 64'h0, 1'b1, 90'h0, 1'b0, 1'b1, 32'h0, 60'h1, 13};
    tbl[2] = '{2'd2, 64'h1, 1'b1, 90'h1, 1'b0, 1'b1, 32'h3, 60'h1, 5};
    tbl[3] = '{2'd0, 64'hDEADBEEF_12345678, 1'b0, 90'h0, 1'b1, 1'b0, 32'h0, 60'h0, 13};
    tbl[4] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 90'h0, 1'b0, 1'b0, 32'h0, 60'h0, 65};
    tbl[5] = '{2'd2, 64'h0123_4567_89AB_CDEF, 1'b0, 90'h0, 1'b0, 1'b0, 32'h0, 60'h0, 5};

    rst_n = 1'b0; abort = 1'b0; seed = 64'd0; sel = 2'd0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    y_const_mode = 1'b1; y_const = 90'h0; cmp_mode = 1'b0; last_sig = 32'd0;
    #12;
    checkOutput("reset_op_vec", 64'(a_op), 64'd0);
    checkOutput("reset_busy", 64'(a_busy), 64'd0);
    checkOutput("reset_vec_idx", 64'(a_idx), 64'd0);
    checkOutput("reset_signature", 64'(a_sig), 64'd0);
`ifdef EXPR_VEC_SEQ_CMP_EN
    checkOutput("reset_first_bad", 64'(b_fb), 64'hFFFF);
`endif
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    for (int i = 0; i < 6; i++) begin
      v.sel       = 2'($urandom_range(0, 2));
      v.seed      = {$urandom(), $urandom()};
      v.ymode     = 1'($urandom_range(0, 1));
      v.yconst    = 90'({$urandom(), $urandom(), $urandom()});
      v.mid_start = 1'b0;
      v.has_exp   = 1'b0;
      v.exp_sig   = 32'd0;
      v.exp_op0   = 60'd0;
      v.lat       = lat_of(v.sel);
      applyStimulus(v);
    end

    // Abort during SETTLE of vector 2 on the 4-vector, 1-settle instance.
    sel = 2'd0; seed = 64'h1; y_const_mode = 1'b0;
    model_run(64'h1, 2, 1'b0, 90'h0, msig2);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checkOutput("abort_busy", 64'(a_busy), 64'd0);
    checkOutput("abort_op_valid", 64'(a_ov), 64'd0);
    checkOutput("abort_vec_idx", 64'(a_idx), 64'd2);
    checkOutput("abort_signature", 64'(a_sig), 64'(msig2));
    dones = 0;
    repeat (20) begin @(posedge clk); #1; if (a_done) dones++; end
    checkOutput("abort_no_done", 64'(dones), 64'd0);
    checkOutput("abort_idx_held", 64'(a_idx), 64'd2);
    applyStimulus(tbl[3]);

    // Start and abort in the same idle cycle: abort wins.
    @(negedge clk); start_a = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; abort = 1'b0;
    checkOutput("start_abort_busy", 64'(a_busy), 64'd0);
    dones = 0;
    repeat (16) begin @(posedge clk); #1; if (a_done || a_busy) dones++; end
    checkOutput("start_abort_no_run", 64'(dones), 64'd0);
    checkOutput("start_abort_sig_held", 64'(a_sig), 64'(last_sig));

    // Asynchronous reset mid-run on the 16-vector instance.
    sel = 2'd1; seed = 64'h5A5A; y_const_mode = 1'b0;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    repeat (10) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    checkOutput("async_rst_op_vec", 64'(b_op), 64'd0);
    checkOutput("async_rst_op_valid", 64'(b_ov), 64'd0);
    checkOutput("async_rst_busy", 64'(b_busy), 64'd0);
    checkOutput("async_rst_done", 64'(b_done), 64'd0);
    checkOutput("async_rst_vec_idx", 64'(b_idx), 64'd0);
    checkOutput("async_rst_signature", 64'(b_sig), 64'd0);
`ifdef EXPR_VEC_SEQ_CMP_EN
    checkOutput("async_rst_mismatch", 64'(b_mm), 64'd0);
    checkOutput("async_rst_first_bad", 64'(b_fb), 64'hFFFF);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Reference mismatches injected on vectors 5 and 9.
    cmp_mode = 1'b1;
    applyStimulus(tbl[4]);
    cmp_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
